pid_sample_sequencer: RTL and testbench

Sequences the fridge PID loop. A prescaler sets the sample rate. On each sample tick the block fetches one temperature reading from the sensor interface through a req/ack handshake, then applies the shadowed setpoint and gains to the PID datapath and pulses its enable for one cycle. After the PID latency it captures the PID output, clamps it to the legal duty range and publishes it to the compressor drive. It also owns the sensor-timeout fault and sample-overrun detection.

---
 rtl/fridge_ctrl_pkg.sv | 33 +++
 rtl/sample_timer.sv | 31 +++
 rtl/pid_sample_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pid_sample_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fridge_ctrl_pkg.sv
// Shared types and helpers for the fridge PID control slice.
// Holds the fixed-point width, sequencer state encoding and the duty clamp.
package fridge_ctrl_pkg;

    localparam int Q8_8_W = 16;

    localparam logic signed [Q8_8_W-1:0] DUTY_SAFE = 16'sh0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        COMPUTE = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        FAULT   = 3'd5
    } seq_state_t;

    // Signed saturation of a Q8.8 value into [lo, hi].
    function automatic logic [Q8_8_W-1:0] clamp_q8_8(
        input logic signed [Q8_8_W-1:0] v,
        input logic signed [Q8_8_W-1:0] lo,
        input logic signed [Q8_8_W-1:0] hi
    );
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sample_timer.sv
// Sample-rate prescaler: counts 0..SAMPLE_DIV-1 while run is high and
// emits a one-cycle tick on the terminal count; parked at zero otherwise.
module sample_timer #(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/pid_sample_sequencer.sv
// Sequences one PID sample per timer tick: fetch a sensor reading, strobe the
// PID with shadowed gains, then clamp and publish its output as compressor duty.
module pid_sample_sequencer
    import fridge_ctrl_pkg::*;
#(
    parameter int                         SAMPLE_DIV  = 1000,
    parameter int                         PID_LATENCY = 2,
    parameter int                         ACK_TIMEOUT = 255,
    parameter logic signed [Q8_8_W-1:0]   OUT_MIN     = 16'sh0000,
    parameter logic signed [Q8_8_W-1:0]   OUT_MAX     = 16'sh6400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [Q8_8_W-1:0] cfg_setpoint,
    input  logic [Q8_8_W-1:0] cfg_kp,
    input  logic [Q8_8_W-1:0] cfg_ki,
    input  logic [Q8_8_W-1:0] cfg_kd,
    input  logic              cfg_update,
    output logic              sensor_req,
    input  logic              sensor_ack,
    input  logic [Q8_8_W-1:0] sensor_data,
    output logic              pid_enable,
    output logic [Q8_8_W-1:0] pid_setpoint,
    output logic [Q8_8_W-1:0] pid_feedback,
    output logic [Q8_8_W-1:0] pid_kp,
    output logic [Q8_8_W-1:0] pid_ki,
    output logic [Q8_8_W-1:0] pid_kd,
    input  logic [Q8_8_W-1:0] pid_output,
    output logic [Q8_8_W-1:0] duty,
    output logic              duty_valid,
    output logic              fault,
    output logic              overrun,
    input  logic              fault_clr,
    output logic [15:0]       sample_count,
    output seq_state_t        state_dbg
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int SW = (PID_LATENCY > 1) ? $clog2(PID_LATENCY + 1) : 1;
    localparam logic [TW-1:0] TO_LAST     = TW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(PID_LATENCY - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              tick;
    logic [TW-1:0]     to_cnt;
    logic [SW-1:0]     st_cnt;
    logic              pend;
    logic [Q8_8_W-1:0] pend_setpoint;
    logic [Q8_8_W-1:0] pend_kp;
    logic [Q8_8_W-1:0] pend_ki;
    logic [Q8_8_W-1:0] pend_kd;

    logic start;
    logic ack_ok;
    logic timeout;
    logic settle_done;
    logic overrun_evt;

    sample_timer #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .run (run),
        .tick(tick)
    );

    assign start       = (state == IDLE) && tick;
    assign overrun_evt = (state != IDLE) && tick;
    assign ack_ok      = (state == REQ) && sensor_ack;
    assign timeout     = (state == REQ) && !sensor_ack && (to_cnt == TO_LAST);
    assign settle_done = (state == SETTLE) && (st_cnt == SETTLE_LAST);
    assign state_dbg   = state;

    // Sensor handshake: sensor_req is high for every REQ cycle; a cycle with
    // sensor_req && sensor_ack transfers sensor_data, and req drops the cycle after.
    always_comb begin
        state_nxt  = state;
        sensor_req = 1'b0;
        pid_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                sensor_req = 1'b1;
                if (ack_ok) begin
                    state_nxt = COMPUTE;
                end else if (timeout) begin
                    state_nxt = FAULT;
                end
            end
            COMPUTE: begin
                pid_enable = 1'b1;
                state_nxt  = SETTLE;
            end
            SETTLE: begin
                if (settle_done) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            FAULT: begin
                if (fault_clr) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            to_cnt <= '0;
            st_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= (state == REQ) ? to_cnt + 1'b1 : '0;
            st_cnt <= (state == SETTLE) ? st_cnt + 1'b1 : '0;
        end
    end

    // Gains only change at the start of a sequence so one sample never mixes sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend          <= 1'b0;
            pend_setpoint <= '0;
            pend_kp       <= '0;
            pend_ki       <= '0;
            pend_kd       <= '0;
            pid_setpoint  <= '0;
            pid_kp        <= '0;
            pid_ki        <= '0;
            pid_kd        <= '0;
        end else begin
            if (cfg_update) begin
                pend_setpoint <= cfg_setpoint;
                pend_kp       <= cfg_kp;
                pend_ki       <= cfg_ki;
                pend_kd       <= cfg_kd;
            end
            if (start) begin
                pend <= 1'b0;
                if (cfg_update) begin
                    pid_setpoint <= cfg_setpoint;
                    pid_kp       <= cfg_kp;
                    pid_ki       <= cfg_ki;
                    pid_kd       <= cfg_kd;
                end else if (pend) begin
                    pid_setpoint <= pend_setpoint;
                    pid_kp       <= pend_kp;
                    pid_ki       <= pend_ki;
                    pid_kd       <= pend_kd;
                end
            end else if (cfg_update) begin
                pend <= 1'b1;
            end
        end
    end

    // duty and duty_valid are registered on the last SETTLE cycle so both are
    // visible together during CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_feedback <= '0;
            duty         <= DUTY_SAFE;
            duty_valid   <= 1'b0;
            sample_count <= '0;
            fault        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (ack_ok) begin
                pid_feedback <= sensor_data;
            end
            duty_valid <= settle_done || timeout;
            if (settle_done) begin
                duty         <= clamp_q8_8(pid_output, OUT_MIN, OUT_MAX);
                sample_count <= sample_count + 16'd1;
            end else if (timeout) begin
                duty <= OUT_MIN;
            end
            if (timeout) begin
                fault <= 1'b1;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
            if (overrun_evt) begin
                overrun <= 1'b1;
            end else if (fault_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed bench for pid_sample_sequencer with a sensor responder, a PID stub
// and a duty scoreboard fed by the stimulus and drained by a monitor.
module tb_pid_sample_sequencer;
    import fridge_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] cfg_setpoint, cfg_kp, cfg_ki, cfg_kd;
    logic        cfg_update;
    logic        sensor_req;
    logic        sensor_ack;
    logic [15:0] sensor_data;
    logic        pid_enable;
    logic [15:0] pid_setpoint, pid_feedback, pid_kp, pid_ki, pid_kd;
    logic [15:0] pid_output;
    logic [15:0] duty;
    logic        duty_valid;
    logic        fault;
    logic        overrun;
    logic        fault_clr;
    logic [15:0] sample_count;
    seq_state_t  state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_cyc  = 0;
    int req_cyc  = 0;

    // scoreboard entries: {fault_entry, sample_count, duty}
    logic [32:0] exp_q[$];
    logic [15:0] exp_fb, exp_sp, exp_kp, exp_ki, exp_kd;

    logic        ack_en;
    int          ack_delay;
    logic [15:0] ack_data;
    int          req_age;
    logic [15:0] stub_val;
    logic [1:0]  pipe;

    pid_sample_sequencer #(
        .SAMPLE_DIV (20),
        .PID_LATENCY(2),
        .ACK_TIMEOUT(255),
        .OUT_MIN    (16'sh0000),
        .OUT_MAX    (16'sh6400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .cfg_setpoint(cfg_setpoint),
        .cfg_kp      (cfg_kp),
        .cfg_ki      (cfg_ki),
        .cfg_kd      (cfg_kd),
        .cfg_update  (cfg_update),
        .sensor_req  (sensor_req),
        .sensor_ack  (sensor_ack),
        .sensor_data (sensor_data),
        .pid_enable  (pid_enable),
        .pid_setpoint(pid_setpoint),
        .pid_feedback(pid_feedback),
        .pid_kp      (pid_kp),
        .pid_ki      (pid_ki),
        .pid_kd      (pid_kd),
        .pid_output  (pid_output),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .fault       (fault),
        .overrun     (overrun),
        .fault_clr   (fault_clr),
        .sample_count(sample_count),
        .state_dbg   (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PID stub: result valid exactly two cycles after the enable strobe
    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= 2'b00;
        else     pipe <= {pipe[0], pid_enable};
    end
    assign pid_output = pipe[1] ? stub_val : 16'h5A5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // which: 0 sensor_req, 1 duty_valid, 2 fault, 3 pid_enable
    task automatic wait_for(input int which, input int max, input string name);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < max) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = sensor_req;
                1:       seen = duty_valid;
                2:       seen = fault;
                3:       seen = pid_enable;
                default: seen = 1'b1;
            endcase
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: event not seen within %0d cycles", name, max);
        end
    endtask

    task automatic start_seq(input logic [15:0] data, input logic [15:0] stub,
                             input logic [15:0] exp_duty, input logic [15:0] exp_cnt);
        ack_data = data;
        exp_fb   = data;
        stub_val = stub;
        exp_q.push_back({1'b0, exp_cnt, exp_duty});
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    // sensor responder: acks after ack_delay cycles of sensor_req
    initial begin
        sensor_ack  = 1'b0;
        sensor_data = 16'h0000;
        req_age     = 0;
        forever begin
            @(negedge clk);
            sensor_ack = 1'b0;
            if (rst || !sensor_req) begin
                req_age = 0;
            end else begin
                if (ack_en && req_age == ack_delay) begin
                    sensor_ack  = 1'b1;
                    sensor_data = ack_data;
                    ack_cyc     = cyc;
                end
                req_age++;
            end
        end
    end

    // monitor: PID operands on the strobe, scoreboard on each duty update
    always @(negedge clk) begin
        if (!rst) begin
            if (pid_enable) begin
                check("pe_latency", 32'(cyc - ack_cyc), 32'd1);
                check("pid_feedback", 32'(pid_feedback), 32'(exp_fb));
                check("pid_setpoint", 32'(pid_setpoint), 32'(exp_sp));
                check("pid_kp", 32'(pid_kp), 32'(exp_kp));
                check("pid_ki", 32'(pid_ki), 32'(exp_ki));
                check("pid_kd", 32'(pid_kd), 32'(exp_kd));
            end
            if (duty_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_duty_valid: duty 0x%0h with nothing expected", duty);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("duty", 32'(duty), 32'(e[15:0]));
                    check("sample_count", 32'(sample_count), 32'(e[31:16]));
                    if (!e[32]) check("dv_latency", 32'(cyc - ack_cyc), 32'd4);
                end
            end
        end
    end

    initial begin
        bit req_seen;
        rst = 1'b1; run = 1'b0; cfg_update = 1'b0; fault_clr = 1'b0;
        cfg_setpoint = 16'h0; cfg_kp = 16'h0; cfg_ki = 16'h0; cfg_kd = 16'h0;
        ack_en = 1'b1; ack_delay = 3; ack_data = 16'h0; stub_val = 16'h0;
        exp_fb = 16'h0; exp_sp = 16'h0; exp_kp = 16'h0; exp_ki = 16'h0; exp_kd = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_sensor_req", 32'(sensor_req), 32'd0);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_duty_valid", 32'(duty_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_count", 32'(sample_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // pending configuration applied at the first sequence
        cfg_setpoint = 16'h0400; cfg_kp = 16'h0100; cfg_ki = 16'h0020; cfg_kd = 16'h0010;
        cfg_update = 1'b1;
        @(negedge clk);
        cfg_update = 1'b0;
        check("kp_before_start", 32'(pid_kp), 32'd0);
        exp_sp = 16'h0400; exp_kp = 16'h0100; exp_ki = 16'h0020; exp_kd = 16'h0010;
        run = 1'b1;

        // nominal sample, then clamp low and high
        start_seq(16'h0500, 16'h0A00, 16'h0A00, 16'd1);
        wait_for(1, 60, "seq1_dv");
        start_seq(16'h0480, 16'hFF00, 16'h0000, 16'd2);
        wait_for(1, 60, "seq2_dv");
        start_seq(16'h0300, 16'h7000, 16'h6400, 16'd3);
        wait_for(1, 60, "seq3_dv");

        // cfg_update during SETTLE is held back until the next sequence
        start_seq(16'h0200, 16'h0A00, 16'h0A00, 16'd4);
        wait_for(3, 60, "seq4_pe");
        @(negedge clk);
        cfg_kp = 16'h0200;
        cfg_update = 1'b1;
        @(negedge clk);
        cfg_update = 1'b0;
        check("kp_held_settle", 32'(pid_kp), 32'h0100);
        wait_for(1, 20, "seq4_dv");
        check("kp_held_capture", 32'(pid_kp), 32'h0100);
        exp_kp = 16'h0200;
        start_seq(16'h0250, 16'h0300, 16'h0300, 16'd5);
        wait_for(1, 60, "seq5_dv");
        check("kp_applied", 32'(pid_kp), 32'h0200);

        // slow ack: a tick lands mid-sequence
        ack_delay = 25;
        start_seq(16'h0600, 16'h0100, 16'h0100, 16'd6);
        wait_for(1, 80, "overrun_dv");
        check("overrun_set", 32'(overrun), 32'd1);
        ack_delay = 3;
        pulse_clr();
        check("overrun_clr", 32'(overrun), 32'd0);

        // missing ack: timeout fault
        ack_en = 1'b0;
        exp_q.push_back({1'b1, 16'd6, 16'h0000});
        wait_for(0, 40, "fault_req");
        req_cyc = cyc;
        wait_for(2, 300, "fault_set");
        check("fault_latency", 32'(cyc - req_cyc), 32'd255);
        check("fault_req_low", 32'(sensor_req), 32'd0);
        check("fault_duty", 32'(duty), 32'd0);
        repeat (25) @(negedge clk);
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_state", 32'(state_dbg), 32'(FAULT));
        ack_en = 1'b1;
        start_seq(16'h0700, 16'h0200, 16'h0200, 16'd7);
        pulse_clr();
        check("fault_cleared", 32'(fault), 32'd0);
        check("clr_state", 32'(state_dbg), 32'(IDLE));
        wait_for(0, 40, "post_clr_req");

        // run dropped mid-sequence: finishes, then stays quiet
        run = 1'b0;
        wait_for(1, 40, "runoff_dv");
        req_seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (sensor_req) req_seen = 1'b1;
        end
        check("runoff_no_req", 32'(req_seen), 32'd0);

        // asynchronous reset during REQ
        run = 1'b1;
        wait_for(0, 40, "rst_req");
        #2 rst = 1'b1;
        #1;
        check("arst_sensor_req", 32'(sensor_req), 32'd0);
        check("arst_duty", 32'(duty), 32'd0);
        check("arst_count", 32'(sample_count), 32'd0);
        check("arst_kp", 32'(pid_kp), 32'd0);
        check("arst_feedback", 32'(pid_feedback), 32'd0);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_state", 32'(state_dbg), 32'(IDLE));
        check("arst_overrun", 32'(overrun), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
